seg_capture16: RTL and testbench
================================

SEG_CAPTURE16 -- requirements
Module: seg_capture16

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical post-sync samples required to accept a digit; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: idle cycles without a digit capture before a partial frame is discarded; legal range 16..2^20.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 anode_n  input  4  scanned digit strobes, active-low, bit i selects digit i, asynchronous to clk.
REQ-006 seg_n  input  8  segment lines, active-low: bit7 = dp, bits6..0 = g,f,e,d,c,b,a; asynchronous to clk.
REQ-007 out_value  output  16  decoded frame, digit i in bits [4i+3:4i].
REQ-008 out_err  output  4  per-digit flag, high = unrecognised pattern in that digit (its nibble is 0).
REQ-009 out_valid / out_ready  output / input  1 / 1  frame handshake.
REQ-010 overrun  output  1  sticky; a complete frame was dropped because the output was still occupied.

Function
REQ-011 anode_n and seg_n SHALL each pass a 2-flop synchroniser; all further logic uses the synchronised values only.
REQ-012 A sample SHALL be a candidate only when exactly one anode bit is low; zero or multiple low bits clear the stability counter.
REQ-013 The stability counter SHALL increment while anode and seg[6:0] equal the previous sample, and SHALL reset to 0 on any change.
REQ-014 A digit SHALL be captured on the cycle the counter reaches STABLE_CYCLES-1, only if that digit is not yet captured in the current frame; later repeats are ignored.
REQ-015 Decode SHALL compare seg[6:0] against the hex table 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (low 7 bits, dp ignored); no match sets the err bit and nibble 0.
REQ-016 States: IDLE (mask empty), COLLECT (1..3 digits captured), HOLD (output occupied); the capture mask is 4 bits.
REQ-017 When the 4th digit is captured, out_value/out_err SHALL load and out_valid SHALL rise on the next cycle (latency 1), and the mask SHALL clear.
REQ-018 out_valid SHALL stay high with stable data until a cycle with out_valid&out_ready; it drops in the following cycle.
REQ-019 Frame completing while out_valid=1 and no handshake that cycle: new frame dropped, overrun set; completion in the handshake cycle itself loads the new frame and keeps out_valid high.
REQ-020 Capture continues during HOLD; the mask fills independently of the output register.
REQ-021 Idle counter SHALL reset on each capture; at TIMEOUT_CYCLES with non-empty mask the mask SHALL clear silently (no output, no overrun).

Reset
REQ-022 rst high SHALL clear synchronisers, stability and idle counters, mask, out_value=0, out_err=0, out_valid=0, overrun=0, state IDLE, within the same edge.
REQ-023 rst mid-frame or during HOLD SHALL discard all partial and pending data; overrun is cleared only by rst.

Configuration
REQ-024 Macro SEG_CAPTURE_DP_EN defined: output port out_dp [3:0] added, carrying seg bit7 (active-high after inversion) of each captured digit, loaded with out_value; dp then also participates in the stability compare.
REQ-025 Macro undefined: no out_dp port, bit7 ignored everywhere.

Structure
REQ-026 Package seg_pkg SHALL hold the 16-entry pattern table, segment bit-index constants and the state enum; the existing encoder and this block share it.
REQ-027 One sub-module seg_pattern_decode (combinational: 7-bit pattern -> 4-bit code + err) SHALL be instantiated once.

Verification
REQ-028 Scan digits 0..3 with 0x99,0xF9,0xA4,0x8E, each held 8 cycles, out_ready=1 -> out_value=0xF214, out_err=0, one out_valid pulse.
REQ-029 Digit 2 driven 0xFF -> out_err=4'b0100, nibble 2 = 0, other nibbles correct.
REQ-030 Pattern held STABLE_CYCLES-1 cycles then changed -> no capture; held STABLE_CYCLES -> capture.
REQ-031 anode_n=4'b0011 for 20 cycles -> no capture, mask unchanged.
REQ-032 out_ready=0, two full frames scanned -> first frame held, overrun=1, second frame lost.
REQ-033 Capture digits 0,1 only, idle TIMEOUT_CYCLES -> mask clears; then full frame 0x1234 -> out_value=0x1234 exactly.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display blocks (the display encoder
// and the seg_capture16 frame grabber).
//   - Segment bit positions within an active-low segment byte.
//   - 16-entry hex glyph table. Values are active-low segment bytes, indexed by
//     the hex digit they display; bit 7 is the decimal point.
//   - Capture state enum.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    localparam int NUM_DIGITS = 4;

    // The packed concatenation lists the MSB first, so entry [0] is 8'hC0 ('0')
    // and entry [15] is 8'h8E ('F').
    localparam logic [15:0][7:0] SEG_HEX_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no digit of the current frame captured yet
        ST_COLLECT = 2'd1,  // 1..3 digits captured
        ST_HOLD    = 2'd2   // output register occupied, waiting for out_ready
    } seg_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Purely combinational decoder from a 7-bit active-low segment pattern to a hex
// code. The decimal point is not part of the input.
// Ports:
//   pattern_i [6:0]  active-low segments g..a
//   code_o    [3:0]  matching hex digit, 0 when no glyph matches
//   err_o            high when the pattern matches no glyph in the table
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = 4'd0;
        err_o  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_HEX_TABLE[i][SEG_BIT_G:SEG_BIT_A]) begin
                code_o = 4'(i);
                err_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_capture16.sv
// -----------------------------------------------------------------------------
// seg_capture16
// Captures a 4-digit multiplexed seven-segment display, as seen on its anode
// and segment pins, and turns it into 16-bit hex frames with a valid/ready
// handshake.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   anode_n  [3:0]  active-low digit strobes (asynchronous)
//   seg_n    [7:0]  active-low segments, bit7 = dp (asynchronous)
//   out_value[15:0] decoded frame, digit i in [4i+3:4i]
//   out_err  [3:0]  per-digit unrecognised-pattern flag
//   out_valid / out_ready  frame handshake
//   overrun         sticky, a completed frame was dropped
//   out_dp   [3:0]  (only with SEG_CAPTURE_DP_EN) decimal points of the frame
// Parameters:
//   STABLE_CYCLES  (2..255)     identical samples needed to accept a digit
//   TIMEOUT_CYCLES (16..2^20)   idle cycles before a partial frame is dropped
// Build option: define SEG_CAPTURE_DP_EN to add out_dp and to make the dp bit
// part of the stability comparison.
// -----------------------------------------------------------------------------
module seg_capture16
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_n,
    input  logic [7:0]  seg_n,
    output logic [15:0] out_value,
    output logic [3:0]  out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
`ifdef SEG_CAPTURE_DP_EN
    ,
    output logic [3:0]  out_dp
`endif
);

    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] STAB_PRE  = 8'(STABLE_CYCLES - 2);
    localparam int         IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    // Bits of the segment byte that must hold still for a digit to be accepted.
`ifdef SEG_CAPTURE_DP_EN
    localparam logic [7:0] CMP_MASK = 8'hFF;
`else
    localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

    logic [3:0]        anode_s1_q, anode_s2_q;
    logic [7:0]        seg_s1_q, seg_s2_q;
    logic [3:0]        prev_anode_q;
    logic [7:0]        prev_seg_q;
    logic [7:0]        stab_q, stab_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [3:0]        mask_q, mask_d;
    logic [15:0]       frame_q, frame_d;
    logic [3:0]        ferr_q, ferr_d;
    logic [3:0]        fdp_q, fdp_d;
    seg_state_t        state_q;

    logic [3:0] act;
    logic       cand;
    logic       same;
    logic [1:0] dig_idx;
    logic [3:0] dig_oh;
    logic       capture;
    logic       complete;
    logic       timeout;
    logic [3:0] mask_set;
    logic [3:0] dec_code;
    logic       dec_err;

    seg_pattern_decode u_decode (
        .pattern_i (seg_s2_q[SEG_BIT_G:SEG_BIT_A]),
        .code_o    (dec_code),
        .err_o     (dec_err)
    );

    always_comb begin
        act  = ~anode_s2_q;
        // Exactly one strobe active: non-zero and a power of two.
        cand = (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
        same = (anode_s2_q == prev_anode_q) &&
               ((seg_s2_q & CMP_MASK) == (prev_seg_q & CMP_MASK));

        dig_idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act[i]) begin
                dig_idx = 2'(i);
            end
        end
        dig_oh = 4'b0001 << dig_idx;

        // The counter saturates at STAB_LAST so a long hold captures only once.
        stab_d = stab_q;
        if (!cand || !same) begin
            stab_d = 8'd0;
        end else if (stab_q != STAB_LAST) begin
            stab_d = stab_q + 8'd1;
        end

        capture  = cand && same && (stab_q == STAB_PRE) && !mask_q[dig_idx];
        mask_set = capture ? (mask_q | dig_oh) : mask_q;
        complete = capture && (mask_set == 4'hF);
        timeout  = !capture && (mask_q != 4'd0) && (idle_q == IDLE_LAST);

        mask_d = (complete || timeout) ? 4'd0 : mask_set;

        idle_d = idle_q + IDLE_ONE;
        if (capture || timeout || (mask_q == 4'd0)) begin
            idle_d = '0;
        end

        // Staging for the frame in progress; every nibble is rewritten before
        // a frame completes, so it never needs clearing.
        frame_d = frame_q;
        ferr_d  = ferr_q;
        fdp_d   = fdp_q;
        if (capture) begin
            frame_d[{dig_idx, 2'b00} +: 4] = dec_err ? 4'd0 : dec_code;
            ferr_d[dig_idx]                = dec_err;
            fdp_d[dig_idx]                 = ~seg_s2_q[SEG_BIT_DP];
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        ferr_q  <= ferr_d;
        fdp_q   <= fdp_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_s1_q   <= 4'd0;
            anode_s2_q   <= 4'd0;
            seg_s1_q     <= 8'd0;
            seg_s2_q     <= 8'd0;
            prev_anode_q <= 4'd0;
            prev_seg_q   <= 8'd0;
            stab_q       <= 8'd0;
            idle_q       <= '0;
            mask_q       <= 4'd0;
            state_q      <= ST_IDLE;
            out_value    <= 16'd0;
            out_err      <= 4'd0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            out_dp       <= 4'd0;
`endif
        end else begin
            anode_s1_q   <= anode_n;
            anode_s2_q   <= anode_s1_q;
            seg_s1_q     <= seg_n;
            seg_s2_q     <= seg_s1_q;
            prev_anode_q <= anode_s2_q;
            prev_seg_q   <= seg_s2_q;
            stab_q       <= stab_d;
            idle_q       <= idle_d;
            mask_q       <= mask_d;

            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (complete) begin
                        out_value <= frame_d;
                        out_err   <= ferr_d;
`ifdef SEG_CAPTURE_DP_EN
                        out_dp    <= fdp_d;
`endif
                        out_valid <= 1'b1;
                        state_q   <= ST_HOLD;
                    end else begin
                        state_q <= (mask_d != 4'd0) ? ST_COLLECT : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (complete) begin
                            // Handshake and completion together: the new
                            // frame replaces the accepted one seamlessly.
                            out_value <= frame_d;
                            out_err   <= ferr_d;
`ifdef SEG_CAPTURE_DP_EN
                            out_dp    <= fdp_d;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            state_q   <= (mask_d != 4'd0) ? ST_COLLECT : ST_IDLE;
                        end
                    end else if (complete) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_capture16.sv
// Bench for seg_capture16: directed scenarios plus randomized frames, all
// checked against a frame-level model of the capture rules.
module tb_seg_capture16;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  anode_n = 4'hF;
    logic [7:0]  seg_n = 8'hFF;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overrun;
`ifdef SEG_CAPTURE_DP_EN
    logic [3:0]  out_dp;
`endif

    seg_capture16 #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .anode_n   (anode_n),
        .seg_n     (seg_n),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef SEG_CAPTURE_DP_EN
        ,
        .out_dp    (out_dp)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] hex_pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Observed handshakes {err, value}, valid pulses and valid-high cycles.
    logic [19:0] obs_q [$];
    int          pulses       = 0;
    int          valid_cycles = 0;
    logic        valid_prev   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                valid_cycles++;
                if (!valid_prev) pulses++;
                if (out_ready === 1'b1) obs_q.push_back({out_err, out_value});
            end
            valid_prev = (out_valid === 1'b1);
        end
    end

    // Frame-level reference model.
    logic [3:0]  m_mask;
    logic [15:0] m_val;
    logic [3:0]  m_errs;
    logic [19:0] exp_q [$];

    function automatic logic [4:0] ref_decode(input logic [7:0] pat);
        for (int i = 0; i < 16; i++) begin
            if (pat[6:0] == hex_pat[i][6:0]) return {1'b0, 4'(i)};
        end
        return 5'h10;
    endfunction

    task automatic model_digit(input int idx, input logic [7:0] pat, input int hold,
                               output logic captured);
        logic [4:0] d;
        captured = 1'b0;
        if (hold >= STABLE && !m_mask[idx]) begin
            d = ref_decode(pat);
            m_mask[idx]        = 1'b1;
            m_val[idx*4 +: 4]  = d[3:0];
            m_errs[idx]        = d[4];
            captured           = 1'b1;
            if (m_mask == 4'hF) begin
                exp_q.push_back({m_errs, m_val});
                m_mask = 4'd0;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one digit for 'hold' cycles; a one-cycle blank gap separates runs.
    task automatic scan(input int idx, input logic [7:0] pat, input int hold, input bit gap);
        logic c;
        anode_n = ~(4'b0001 << idx);
        seg_n   = pat;
        step(hold);
        model_digit(idx, pat, hold, c);
        if (gap) begin
            anode_n = 4'hF;
            seg_n   = 8'hFF;
            step(1);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        anode_n   = 4'hF;
        seg_n     = 8'hFF;
        out_ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        m_mask = 4'd0;
        m_val  = 16'd0;
        m_errs = 4'd0;
        exp_q.delete();
        obs_q.delete();
        pulses       = 0;
        valid_cycles = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_value !== 16'h0) begin miscompares++; $display("FAIL reset_value: got %h want 0000", out_value); end
        vectors++;
        if (out_err !== 4'h0) begin miscompares++; $display("FAIL reset_err: got %b want 0000", out_err); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        scan(0, 8'h99, 8, 1);
        scan(1, 8'hF9, 8, 1);
        scan(2, 8'hA4, 8, 1);
        scan(3, 8'h8E, 8, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL basic_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h0F214) begin
            miscompares++; $display("FAIL basic_frame: got %h want 0F214", obs_q[0]);
        end
        vectors++;
        if (pulses != 1 || valid_cycles != 1) begin
            miscompares++; $display("FAIL basic_pulse: got %0d pulses %0d cycles want 1 1", pulses, valid_cycles);
        end
    endtask

    task automatic test_err_digit();
        do_reset();
        scan(0, 8'hC0, 8, 1);
        scan(1, 8'hB0, 8, 1);
        scan(2, 8'hFF, 8, 1);
        scan(3, 8'h80, 8, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL err_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== {4'b0100, 16'h8030}) begin
            miscompares++; $display("FAIL err_frame: got %h want 48030", obs_q[0]);
        end
    endtask

    task automatic test_stability();
        do_reset();
        scan(0, 8'hF9, STABLE - 1, 0);
        scan(0, 8'hA4, STABLE - 1, 1);
        scan(1, 8'hB0, 8, 1);
        scan(2, 8'h99, 8, 1);
        scan(3, 8'h92, 8, 1);
        step(4);
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL stab_short: got %0d pulses want 0", pulses); end
        scan(0, 8'h82, STABLE, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL stab_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h05436) begin
            miscompares++; $display("FAIL stab_frame: got %h want 05436", obs_q[0]);
        end
    endtask

    task automatic test_multi_anode();
        do_reset();
        scan(0, 8'h92, 8, 1);
        anode_n = 4'b0011;
        seg_n   = 8'hC0;
        step(20);
        anode_n = 4'hF;
        seg_n   = 8'hFF;
        step(1);
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL multi_pulse: got %0d pulses want 0", pulses); end
        scan(1, 8'hF8, 8, 1);
        scan(2, 8'h80, 8, 1);
        scan(3, 8'h90, 8, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL multi_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h09875) begin
            miscompares++; $display("FAIL multi_frame: got %h want 09875", obs_q[0]);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        scan(0, 8'hC0, 8, 1);
        scan(1, 8'hF9, 8, 1);
        scan(2, 8'hA4, 8, 1);
        scan(3, 8'hB0, 8, 1);
        step(4);
        vectors++;
        if (out_valid !== 1'b1 || out_value !== 16'h3210 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_first: got v=%b val=%h ovr=%b want 1 3210 0", out_valid, out_value, overrun);
        end
        scan(0, 8'h99, 8, 1);
        scan(1, 8'h92, 8, 1);
        scan(2, 8'h82, 8, 1);
        scan(3, 8'hF8, 8, 1);
        step(4);
        vectors++;
        if (out_valid !== 1'b1 || out_value !== 16'h3210 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_second: got v=%b val=%h ovr=%b want 1 3210 1", out_valid, out_value, overrun);
        end
        out_ready = 1'b1;
        step(3);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL ovr_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h03210) begin
            miscompares++; $display("FAIL ovr_frame: got %h want 03210", obs_q[0]);
        end
        vectors++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++; $display("FAIL ovr_after: got v=%b ovr=%b want 0 1", out_valid, overrun);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        scan(0, 8'hC6, 8, 1);
        scan(1, 8'h88, 8, 1);
        scan(2, 8'h83, 8, 1);
        do_reset();
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        scan(0, 8'hA1, 8, 1);
        scan(1, 8'h86, 8, 1);
        scan(2, 8'hF9, 8, 1);
        scan(3, 8'h90, 8, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL rst_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h091ED) begin
            miscompares++; $display("FAIL rst_frame: got %h want 091ED", obs_q[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        scan(0, 8'h90, 8, 1);
        scan(1, 8'h80, 8, 1);
        step(TIMEOUT + 20);
        m_mask = 4'd0;
        vectors++;
        if (pulses != 0 || overrun !== 1'b0) begin
            miscompares++; $display("FAIL tmo_silent: got %0d pulses ovr=%b want 0 0", pulses, overrun);
        end
        scan(0, 8'h99, 8, 1);
        scan(1, 8'hB0, 8, 1);
        scan(2, 8'hA4, 8, 1);
        scan(3, 8'hF9, 8, 1);
        step(4);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL tmo_count: got %0d frames want 1", obs_q.size());
        end else if (obs_q[0] !== 20'h01234) begin
            miscompares++; $display("FAIL tmo_frame: got %h want 01234", obs_q[0]);
        end
    endtask

    task automatic test_random(input int nframes);
        int         idx, hold, stall, iter;
        logic [7:0] pat;
        logic       c;
        do_reset();
        stall = 0;
        iter  = 0;
        while (exp_q.size() < nframes && iter < nframes * 200) begin
            iter++;
            idx  = $urandom_range(3);
            hold = $urandom_range(2, 9);
            if ($urandom_range(3) == 0) begin
                pat = 8'($urandom());
            end else begin
                pat    = hex_pat[$urandom_range(15)];
                pat[7] = 1'($urandom_range(1));
            end
            if (stall >= 8) begin
                for (int i = 3; i >= 0; i--) if (!m_mask[i]) idx = i;
                hold = 8;
            end
            anode_n = ~(4'b0001 << idx);
            seg_n   = pat;
            step(hold);
            model_digit(idx, pat, hold, c);
            anode_n = 4'hF;
            seg_n   = 8'hFF;
            step(1);
            stall = c ? 0 : stall + 1;
        end
        step(6);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL rand_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rand_frame%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_digit();
        test_stability();
        test_multi_anode();
        test_overrun();
        test_reset_midframe();
        test_timeout();
        test_random(30);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
